// File: rtl/spi_reg_intf.sv
// spi_reg_intf
// ------------
// SPI slave front end (mode 0) of the accelerator register interface.
// It holds NUM_REGS 16-bit control registers. A host writes and reads them
// with 24-bit frames: one command byte, then 16 data bits, MSB first.
// Command byte layout: bit7 = read (1) / write (0); bits 6:4 are ignored;
// bits 3:0 select the address.
//
// All state is in the clk domain. SCLK, SS and MOSI are treated as
// asynchronous inputs. Each one is synchronised by two flops. A third flop
// on SCLK and SS turns level changes into single-cycle edge strobes. The
// clk frequency must be at least 8x the SCLK frequency.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   SCLK  in   SPI clock from the host, idles low
//   SS    in   slave select, active low
//   MOSI  in   host-to-slave data, sampled on SCLK rising edges
//   MISO  out  slave-to-host data, registered, changes after SCLK falls
//
// Build option:
//   REG_INTF_ID_EN  When defined, address 0 is a read-only ID register that
//                   returns ID_VALUE, and writes to it are dropped.
//                   When undefined, address 0 is a normal register.

`timescale 1ns/1ps

module spi_reg_intf #(
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] ID_VALUE = 16'hA5C3
) (
    input  logic clk,
    input  logic rst,
    input  logic SCLK,
    input  logic SS,
    input  logic MOSI,
    output logic MISO
);

`ifdef REG_INTF_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    localparam logic [4:0] FRAME_BITS = 5'd24;

    // Synchronisers. Index 0 is the first flop after the pin. The SCLK and
    // SS chains have one extra stage, which is used only for edge detection.
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] ss_sync_q,   ss_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    // Frame state
    logic [4:0]  bit_cnt_q,   bit_cnt_d;
    logic [14:0] shift_in_q,  shift_in_d;   // the last received bit comes straight from mosi
    logic        rd_frame_q,  rd_frame_d;   // current frame is a read past its command byte
    logic [3:0]  addr_q,      addr_d;
    logic [15:0] out_shift_q, out_shift_d;
    logic        miso_q,      miso_d;

    // Pending register write, committed one clk after the 24th rising edge
    logic        wr_en_q,     wr_en_d;
    logic [15:0] wr_data_q,   wr_data_d;

    // Register bank
    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] regs_d [NUM_REGS];

    // Synchronised levels and edge strobes
    logic sclk_rise, sclk_fall, ss_fall, ss_rise, ss_low, mosi_s;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_rd_data;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        ss_sync_d   = {ss_sync_q[1:0], SS};
        mosi_sync_d = {mosi_sync_q[0], MOSI};
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign ss_low    = ~ss_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];

    // On the 8th rising edge, the address is the three low bits already
    // shifted in plus the bit arriving now. Looking it up here lets the read
    // data be loaded on the same edge.
    assign cmd_addr = {shift_in_q[2:0], mosi_s};

    always_comb begin
        cmd_rd_data = 16'h0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == 4'(i)) begin
                cmd_rd_data = regs_q[i];
            end
        end
    end

    // Frame sequencing
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        rd_frame_d  = rd_frame_q;
        addr_d      = addr_q;
        out_shift_d = out_shift_q;
        miso_d      = miso_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;

        if (ss_fall) begin
            // A new frame starts from a clean state.
            bit_cnt_d   = 5'd0;
            shift_in_d  = 15'd0;
            out_shift_d = 16'h0000;
            rd_frame_d  = 1'b0;
            miso_d      = 1'b0;
        end else if (ss_rise) begin
            // The frame ended or was aborted. Abandoning a frame needs no
            // further action, because a write is only queued after bit 24.
            bit_cnt_d  = 5'd0;
            rd_frame_d = 1'b0;
        end else if (ss_low) begin
            // The counter saturates at 24, so any extra bits are ignored.
            if (sclk_rise && (bit_cnt_q < FRAME_BITS)) begin
                shift_in_d = {shift_in_q[13:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 5'd1;

                if (bit_cnt_q == 5'd7) begin
                    // The command byte is complete: shift_in_q[6] is the
                    // R/W bit, and bits 5:3 are reserved.
                    addr_d     = cmd_addr;
                    rd_frame_d = shift_in_q[6];
                    if (shift_in_q[6]) begin
                        out_shift_d = cmd_rd_data;
                    end
                end

                if ((bit_cnt_q == FRAME_BITS - 5'd1) && !rd_frame_q) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = {shift_in_q[14:0], mosi_s};
                end
            end

            if (sclk_fall && rd_frame_q) begin
                miso_d      = out_shift_q[15];
                out_shift_d = {out_shift_q[14:0], 1'b0};
            end
        end

        // MISO is held low whenever the host is not selecting this slave.
        if (ss_sync_q[1]) begin
            miso_d = 1'b0;
        end
    end

    // Register bank update. With the ID option enabled, address 0 keeps its
    // reset value forever.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en_q && (addr_q == 4'(i)) && !(ID_EN && (i == 0))) begin
                regs_d[i] = wr_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= 5'd0;
            shift_in_q  <= 15'd0;
            rd_frame_q  <= 1'b0;
            addr_q      <= 4'd0;
            out_shift_q <= 16'h0000;
            miso_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 16'h0000;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (ID_EN && (i == 0)) ? ID_VALUE : 16'h0000;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            rd_frame_q  <= rd_frame_d;
            addr_q      <= addr_d;
            out_shift_q <= out_shift_d;
            miso_q      <= miso_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign MISO = miso_q;

endmodule

// File: tb/tb_spi_reg_intf.sv
// Testbench for spi_reg_intf.
// The bench acts as the SPI host. It uses SCLK phases of 6 clk cycles and
// samples MISO just before each SCLK rising edge. A register-array model
// predicts every MISO bit, and a single compare process checks each
// prediction. Fixed frames pin the model to literal values. After them,
// random frames run: writes, reads, aborted frames and over-long frames.

`timescale 1ns/1ps

module tb_spi_reg_intf;

    logic clk = 1'b0;
    logic rst;
    logic SCLK;
    logic SS;
    logic MOSI;
    logic MISO;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [15:0] ID_VAL = 16'hA5C3;
    localparam int HALF = 6;   // clk cycles per SCLK phase

    spi_reg_intf #(.NUM_REGS(16), .ID_VALUE(ID_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .SCLK(SCLK),
        .SS  (SS),
        .MOSI(MOSI),
        .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Behavioural model: the register contents as the host should see them.
    logic [15:0] model_regs [16];

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a);
`ifdef REG_INTF_ID_EN
        if (a == 4'd0) return ID_VAL;
`endif
        return model_regs[a];
    endfunction

    // A frame writes only if it is a write command that delivered all
    // 24 bits.
    function automatic void model_frame(input logic [7:0] cmd, input logic [15:0] data,
                                        input int nbits);
        if (nbits >= 24 && !cmd[7]) model_regs[cmd[3:0]] = data;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // The single compare process for MISO samples.
    event  sample_ev;
    logic  exp_miso;
    string exp_name;

    initial begin
        forever begin
            @(sample_ev);
            check(exp_name, {31'd0, MISO}, {31'd0, exp_miso});
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame of nbits SCLK pulses. Return the 16 bits seen on MISO
    // in the data phase.
    task automatic do_frame(input logic [7:0] cmd, input logic [15:0] data,
                            input int nbits, output logic [15:0] rd);
        logic [23:0] word;
        logic [15:0] exp_rd;
        word   = {cmd, data};
        exp_rd = model_read(cmd[3:0]);
        rd     = 16'h0000;
        SS = 1'b0;
        wait_clks(HALF);
        for (int k = 0; k < nbits; k++) begin
            MOSI = (k < 24) ? word[23 - k] : 1'($urandom);
            wait_clks(HALF);
            exp_miso = (cmd[7] && k >= 8 && k < 24) ? exp_rd[23 - k] : 1'b0;
            exp_name = $sformatf("miso bit%0d cmd%02h", k, cmd);
            -> sample_ev;
            if (k >= 8 && k < 24) rd[23 - k] = MISO;
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
        wait_clks(HALF);
        SS   = 1'b1;
        MOSI = 1'b0;
        wait_clks(8);
        exp_miso = 1'b0;
        exp_name = $sformatf("miso idle after cmd%02h", cmd);
        -> sample_ev;
        model_frame(cmd, data, nbits);
        wait_clks(2);
        $display("frame cmd=%02h data=%04h bits=%0d miso_word=%04h", cmd, data, nbits, rd);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        wait_clks(n);
        rst = 1'b0;
        model_reset();
        wait_clks(3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        logic [7:0]  cmd;
        int          nb;
        int          r;

        rst  = 1'b1;
        SS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        model_reset();
        wait_clks(5);
        check("reset miso", {31'd0, MISO}, 32'd0);
        rst = 1'b0;
        wait_clks(3);

        // Read after reset
        do_frame(8'h85, 16'h0000, 24, rd);
        check("read a5 after reset", {16'd0, rd}, 32'h0000);

        // Write, then read back
        do_frame(8'h03, 16'h1234, 24, rd);
        do_frame(8'h83, 16'h0000, 24, rd);
        check("read a3 after write", {16'd0, rd}, 32'h1234);

        // An aborted write must leave the register unchanged.
        do_frame(8'h07, 16'hBEEF, 20, rd);
        do_frame(8'h87, 16'h0000, 24, rd);
        check("read a7 after abort", {16'd0, rd}, 32'h0000);

        // Extra SCLK pulses are ignored.
        do_frame(8'h0F, 16'hFFFF, 32, rd);
        do_frame(8'h8F, 16'h0000, 24, rd);
        check("read a15 after long frame", {16'd0, rd}, 32'hFFFF);
        do_frame(8'h8E, 16'h0000, 24, rd);
        check("read a14 untouched", {16'd0, rd}, 32'h0000);

        // Address 0: an ID register or a plain register
        do_frame(8'h00, 16'h0000, 24, rd);
        do_frame(8'h80, 16'h0000, 24, rd);
`ifdef REG_INTF_ID_EN
        check("read a0 id", {16'd0, rd}, 32'hA5C3);
`else
        check("read a0 plain", {16'd0, rd}, 32'h0000);
`endif

        // Reserved command bits set, then reset clears registers.
        do_frame(8'h72, 16'h00AA, 24, rd);
        do_frame(8'hF2, 16'h0000, 24, rd);
        check("read a2 before reset", {16'd0, rd}, 32'h00AA);
        do_reset(3);
        do_frame(8'h82, 16'h0000, 24, rd);
        check("read a2 after reset", {16'd0, rd}, 32'h0000);

        // Random frames checked against the model
        for (int n = 0; n < 40; n++) begin
            cmd = 8'($urandom);
            r   = $urandom_range(0, 9);
            if (r < 7)       nb = 24;
            else if (r == 7) nb = $urandom_range(9, 23);
            else             nb = $urandom_range(25, 32);
            do_frame(cmd, 16'($urandom), nb, rd);
        end

        // Read back every register.
        for (int a = 0; a < 16; a++) begin
            logic [15:0] exp_v;
            exp_v = model_read(4'(a));
            do_frame({1'b1, 3'($urandom), 4'(a)}, 16'($urandom), 24, rd);
            check($sformatf("sweep a%0d", a), {16'd0, rd}, {16'd0, exp_v});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
